// File: rtl/synchronizer_if.sv
// Bus bundle for the multi-bit input synchronizer: raw async input and synchronized/edge outputs.
interface synchronizer_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] in_line;
  logic [WIDTH-1:0] out_line;
  logic [WIDTH-1:0] rise_edge;
  logic [WIDTH-1:0] fall_edge;

  modport master (
    output in_line,
    input  out_line,
    input  rise_edge,
    input  fall_edge
  );

  modport slave (
    input  in_line,
    output out_line,
    output rise_edge,
    output fall_edge
  );
endinterface

// File: rtl/synchronizer.sv
// Per-bit flip-flop chain synchronizer for asynchronous inputs, with single-cycle
// rise/fall pulses derived from the synchronized value.
module synchronizer #(
  parameter int unsigned      WIDTH      = 1,
  parameter int unsigned      STAGES     = 2,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic            sys_clk,
  input  logic            rst_n,
  synchronizer_if.slave   bus
);

  localparam int unsigned NSTG = (STAGES < 2) ? 2 : STAGES;

  // Chain registers must stay plain flops next to each other: no retiming, no SRL.
  (* ASYNC_REG = "TRUE", shreg_extract = "no", dont_retime = "true" *)
  logic [WIDTH-1:0] stage_q [NSTG];
  logic [WIDTH-1:0] stage_d [NSTG];
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] prev_d;

  always_comb begin
    stage_d[0] = bus.in_line;
    for (int unsigned k = 1; k < NSTG; k++) begin
      stage_d[k] = stage_q[k-1];
    end
    prev_d = stage_q[NSTG-1];
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NSTG; k++) begin
        stage_q[k] <= INIT_VALUE;
      end
      prev_q <= INIT_VALUE;
    end else begin
      for (int unsigned k = 0; k < NSTG; k++) begin
        stage_q[k] <= stage_d[k];
      end
      prev_q <= prev_d;
    end
  end

  assign bus.out_line  = stage_q[NSTG-1];
  assign bus.rise_edge = stage_q[NSTG-1] & ~prev_q;
  assign bus.fall_edge = ~stage_q[NSTG-1] & prev_q;

endmodule

// File: tb/tb_synchronizer.sv
// Directed bench for synchronizer: reset, slow/per-clock/sub-period stimulus,
// async mid-stream reset, and alternative parameterisations.
module tb_synchronizer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  synchronizer_if #(.WIDTH(4)) bus0 ();
  synchronizer_if #(.WIDTH(1)) bus1 ();
  synchronizer_if #(.WIDTH(2)) bus2 ();

  synchronizer #(.WIDTH(4), .STAGES(2), .INIT_VALUE(4'h0)) dut0 (
    .sys_clk (clk),
    .rst_n   (rst_n),
    .bus     (bus0)
  );

  synchronizer #(.WIDTH(1), .STAGES(3), .INIT_VALUE(1'b0)) dut1 (
    .sys_clk (clk),
    .rst_n   (rst_n),
    .bus     (bus1)
  );

  // STAGES=1 must behave as a 2-stage chain; non-zero INIT_VALUE.
  synchronizer #(.WIDTH(2), .STAGES(1), .INIT_VALUE(2'b10)) dut2 (
    .sys_clk (clk),
    .rst_n   (rst_n),
    .bus     (bus2)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [3:0] o, input logic [3:0] r, input logic [3:0] f,
                     input logic [3:0] eo, input logic [3:0] er, input logic [3:0] ef);
    checks++;
    assert (o === eo) else begin
      errors++;
      $error("FAIL %s out_line got %h exp %h", tag, o, eo);
    end
    checks++;
    assert (r === er) else begin
      errors++;
      $error("FAIL %s rise_edge got %h exp %h", tag, r, er);
    end
    checks++;
    assert (f === ef) else begin
      errors++;
      $error("FAIL %s fall_edge got %h exp %h", tag, f, ef);
    end
  endtask

  task automatic c0(input string tag, input logic [3:0] eo, input logic [3:0] er, input logic [3:0] ef);
    chk(tag, bus0.out_line, bus0.rise_edge, bus0.fall_edge, eo, er, ef);
  endtask

  task automatic c1(input string tag, input logic [3:0] eo, input logic [3:0] er, input logic [3:0] ef);
    chk(tag, {3'b0, bus1.out_line}, {3'b0, bus1.rise_edge}, {3'b0, bus1.fall_edge}, eo, er, ef);
  endtask

  task automatic c2(input string tag, input logic [3:0] eo, input logic [3:0] er, input logic [3:0] ef);
    chk(tag, {2'b0, bus2.out_line}, {2'b0, bus2.rise_edge}, {2'b0, bus2.fall_edge}, eo, er, ef);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus0.in_line = 4'hF;
    bus1.in_line = 1'b0;
    bus2.in_line = 2'b10;

    // Reset held with clocks running
    tick(); tick(); tick();
    c0("rst_hold", 4'h0, 4'h0, 4'h0);
    c1("rst_hold_w1", 4'h0, 4'h0, 4'h0);
    c2("rst_hold_init", 4'h2, 4'h0, 4'h0);

    rst_n = 1'b1;
    tick(); c0("rel_e1", 4'h0, 4'h0, 4'h0);
    c2("rel_e1_init", 4'h2, 4'h0, 4'h0);
    tick(); c0("rel_e2", 4'hF, 4'hF, 4'h0);
    c2("rel_e2_init", 4'h2, 4'h0, 4'h0);
    tick(); c0("rel_e3", 4'hF, 4'h0, 4'h0);

    // Slow stimulus, each value held 4 clocks
    bus0.in_line = 4'hC;
    tick(); c0("slow_c1", 4'hF, 4'h0, 4'h0);
    tick(); c0("slow_c2", 4'hC, 4'h0, 4'h3);
    tick(); c0("slow_c3", 4'hC, 4'h0, 4'h0);
    tick(); c0("slow_c4", 4'hC, 4'h0, 4'h0);
    bus0.in_line = 4'h1;
    tick(); c0("slow_1a", 4'hC, 4'h0, 4'h0);
    tick(); c0("slow_1b", 4'h1, 4'h1, 4'hC);
    tick(); c0("slow_1c", 4'h1, 4'h0, 4'h0);
    tick(); c0("slow_1d", 4'h1, 4'h0, 4'h0);
    bus0.in_line = 4'h5;
    tick(); c0("slow_5a", 4'h1, 4'h0, 4'h0);
    tick(); c0("slow_5b", 4'h5, 4'h4, 4'h0);
    tick(); c0("slow_5c", 4'h5, 4'h0, 4'h0);
    tick(); c0("slow_5d", 4'h5, 4'h0, 4'h0);

    // One value per clock
    bus0.in_line = 4'h3;
    tick(); c0("pc_a", 4'h5, 4'h0, 4'h0);
    bus0.in_line = 4'h9;
    tick(); c0("pc_3", 4'h3, 4'h2, 4'h4);
    bus0.in_line = 4'hB;
    tick(); c0("pc_9", 4'h9, 4'h8, 4'h2);
    bus0.in_line = 4'h4;
    tick(); c0("pc_B", 4'hB, 4'h2, 4'h0);
    tick(); c0("pc_4", 4'h4, 4'h4, 4'hB);
    tick(); c0("pc_hold", 4'h4, 4'h0, 4'h0);

    // Quarter-period values: only 4 and F land on rising edges
    bus0.in_line = 4'h3; #5;
    bus0.in_line = 4'h9; #5;
    bus0.in_line = 4'hB; #5;
    bus0.in_line = 4'h4; #5;
    bus0.in_line = 4'h1; #5;
    bus0.in_line = 4'h0; #5;
    bus0.in_line = 4'hA; #5;
    bus0.in_line = 4'hF; #5;
    c0("sub_a", 4'h4, 4'h0, 4'h0);
    tick(); c0("sub_b", 4'hF, 4'hB, 4'h0);
    tick(); c0("sub_c", 4'hF, 4'h0, 4'h0);

    // Async reset in the middle of a clock period
    bus0.in_line = 4'hB;
    tick(); c0("mid_pre1", 4'hF, 4'h0, 4'h0);
    tick(); c0("mid_pre2", 4'hB, 4'h0, 4'h4);
    #5;
    rst_n = 1'b0;
    bus0.in_line = 4'h6;
    #1;
    c0("mid_async", 4'h0, 4'h0, 4'h0);
    tick(); c0("mid_held", 4'h0, 4'h0, 4'h0);
    rst_n = 1'b1;
    tick(); c0("mid_rel1", 4'h0, 4'h0, 4'h0);
    tick(); c0("mid_rel2", 4'h6, 4'h6, 4'h0);

    // WIDTH=1, STAGES=3 step
    bus1.in_line = 1'b1;
    tick(); c1("w1_e1", 4'h0, 4'h0, 4'h0);
    tick(); c1("w1_e2", 4'h0, 4'h0, 4'h0);
    tick(); c1("w1_e3", 4'h1, 4'h1, 4'h0);
    tick(); c1("w1_e4", 4'h1, 4'h0, 4'h0);

    // STAGES clamp: 2-edge latency, both edges on a bit swap
    bus2.in_line = 2'b01;
    tick(); c2("clamp_e1", 4'h2, 4'h0, 4'h0);
    tick(); c2("clamp_e2", 4'h1, 4'h1, 4'h2);
    tick(); c2("clamp_e3", 4'h1, 4'h0, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
